// File: rtl/avg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : avg_pkg
//  Purpose  : Shared definitions for the Project2 moving-average datapath.
//             Holds the sequencer FSM state encoding and the default window
//             depth, so that the sequencer, window buffer and accumulator
//             all agree on the number of samples.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package avg_pkg;

  // log2 of the default averaging window depth (8 samples)
  localparam int c_win_log2_default = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_ACC   = 3'd3,
    S_DISP  = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/avg_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : avg_sample_sequencer_if
//  Purpose  : Sample-fetch handshake and datapath strobes between the
//             sequencer (master) and the source/window buffer/accumulator/
//             display side (slave).
//  Signals  : smp_req   - sample request, level, held until ack
//             smp_ack   - sample valid, one-cycle pulse from the source
//             buf_wr    - window-buffer write strobe
//             buf_addr  - window-buffer write pointer
//             acc_en    - accumulator update pulse
//             disp_load - latch average into the HEX display registers
//  Revision : 1.0  initial release
// ============================================================================
interface avg_sample_sequencer_if
  import avg_pkg::*;
#(
  parameter int WIN_LOG2 = c_win_log2_default
);
  logic                smp_req;
  logic                smp_ack;
  logic                buf_wr;
  logic [WIN_LOG2-1:0] buf_addr;
  logic                acc_en;
  logic                disp_load;

  modport master (
    output smp_req, buf_wr, buf_addr, acc_en, disp_load,
    input  smp_ack
  );

  modport slave (
    input  smp_req, buf_wr, buf_addr, acc_en, disp_load,
    output smp_ack
  );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Synchronises an active-low pushbutton, debounces it and emits
//             a one-cycle pulse on each accepted press (stable 1->0).
//  Ports    : clk      - system clock
//             rst      - asynchronous active-high reset
//             i_btn_n  - raw active-low button, asynchronous to clk
//             o_press  - registered one-cycle press pulse
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce
  import avg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_btn_n,
  output logic      o_press
);
  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic               r_press;
  logic [c_cnt_w-1:0] r_cnt;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any return to the accepted level restarts the count,
  // so a new level is taken after DEBOUNCE_CYCLES unbroken cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule
`default_nettype wire

// File: rtl/avg_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : avg_sample_sequencer
//  Purpose  : Controller for the moving-average datapath. Generates the
//             periodic sample tick, fetches one sample per tick over a
//             req/ack handshake, then sequences buffer write, accumulator
//             update and display latch. A debounced button toggles run/hold.
//  Ports    : CLOCK_50    - system clock
//             reset       - asynchronous active-high reset
//             toggleBtn   - raw active-low pushbutton
//             bus         - handshake/strobe interface (master side)
//             running     - 1 = run, 0 = hold (LEDG)
//             window_full - sticky, first full window has been written
//             overrun     - sticky, a tick arrived while busy
//  Revision : 1.0  initial release
// ============================================================================
module avg_sample_sequencer
  import avg_pkg::*;
#(
  parameter int SAMPLE_DIV      = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WIN_LOG2        = c_win_log2_default
) (
  input  wire logic              CLOCK_50,
  input  wire logic              reset,
  input  wire logic              toggleBtn,
  avg_sample_sequencer_if.master bus,
  output logic                   running,
  output logic                   window_full,
  output logic                   overrun
);
  localparam int c_div_w = $clog2(SAMPLE_DIV);
  localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(SAMPLE_DIV - 1);
  localparam logic [WIN_LOG2-1:0] c_ptr_last = '1;

  logic                w_press;
  logic                w_tick;
  logic                w_full_next;
  seq_state_t          r_state;
  seq_state_t          w_next;
  logic                r_running;
  logic [c_div_w-1:0]  r_div_cnt;
  logic [WIN_LOG2-1:0] r_wr_ptr;
  logic                r_smp_req;
  logic                r_buf_wr;
  logic                r_acc_en;
  logic                r_disp_load;
  logic                r_window_full;
  logic                r_overrun;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (CLOCK_50),
    .rst     (reset),
    .i_btn_n (toggleBtn),
    .o_press (w_press)
  );

  // Run/hold mode flop and tick divider. The divider is parked at 0 in
  // hold mode so that resuming always gives a full period before a tick.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_running <= 1'b1;
      r_div_cnt <= '0;
    end else begin
      if (w_press) begin
        r_running <= ~r_running;
      end
      if (!r_running || r_div_cnt == c_div_last) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  assign w_tick = r_running && (r_div_cnt == c_div_last);

  always_comb begin
    w_next      = r_state;
    w_full_next = r_window_full | ((r_state == S_ACC) && (r_wr_ptr == c_ptr_last));
    case (r_state)
      S_IDLE:  if (w_tick) w_next = S_REQ;
      S_REQ:   if (bus.smp_ack) w_next = S_WRITE;
      S_WRITE: w_next = S_ACC;
      S_ACC:   w_next = S_DISP;
      S_DISP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so that every output comes
  // straight from a flop and lines up with the state it belongs to.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_smp_req     <= 1'b0;
      r_buf_wr      <= 1'b0;
      r_acc_en      <= 1'b0;
      r_disp_load   <= 1'b0;
      r_wr_ptr      <= '0;
      r_window_full <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_smp_req     <= (w_next == S_REQ);
      r_buf_wr      <= (w_next == S_WRITE);
      r_acc_en      <= (w_next == S_ACC);
      r_disp_load   <= (w_next == S_DISP) && w_full_next;
      r_window_full <= w_full_next;
      if (r_state == S_ACC) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.smp_req   = r_smp_req;
  assign bus.buf_wr    = r_buf_wr;
  assign bus.buf_addr  = r_wr_ptr;
  assign bus.acc_en    = r_acc_en;
  assign bus.disp_load = r_disp_load;
  assign running       = r_running;
  assign window_full   = r_window_full;
  assign overrun       = r_overrun;
endmodule
`default_nettype wire

// File: doc/avg_sample_sequencer.md
# avg_sample_sequencer

Controller for the Project2 moving-average datapath. It generates the periodic sample tick from `CLOCK_50` and fetches one sample per tick from the sample source over a req/ack handshake. It then sequences the window-buffer write, the accumulator update and the display latch that drives the HEX outputs. It also debounces `toggleBtn` into a run/hold mode shown on `LEDG`.

## Interface
- `SAMPLE_DIV`, 50000: clock cycles per sample tick (1 kHz at 50 MHz); minimum 8.
- `DEBOUNCE_CYCLES`, 500000: cycles a new button level must stay stable before it is accepted (10 ms).
- `WIN_LOG2`, 3: log2 of the averaging window depth (8 samples).
- `CLOCK_50`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `toggleBtn`  in  1  raw pushbutton, active-low, asynchronous to `CLOCK_50`.
- `smp_req`  out  1  sample request to the source; level, held until ack.
- `smp_ack`  in  1  sample-valid from the source; one-cycle pulse.
- `buf_wr`  out  1  window-buffer write strobe; one cycle.
- `buf_addr`  out  WIN_LOG2  window-buffer write pointer.
- `acc_en`  out  1  accumulator update pulse (add new sample, subtract evicted sample).
- `disp_load`  out  1  latch the average into the HEX display registers; one cycle.
- `running`  out  1  1 = run mode, 0 = hold mode; drives `LEDG`.
- `window_full`  out  1  sticky; set once the buffer has held 2^WIN_LOG2 samples.
- `overrun`  out  1  sticky; set when a tick arrives while a transaction is in progress.

## Operation
- Button path: 2-flop synchronizer feeds a debounce counter. The stable level updates only after `DEBOUNCE_CYCLES` consecutive cycles at the new value. A stable 1→0 transition (press) toggles `running`. Release has no effect.
- Tick counter: counts 0..SAMPLE_DIV-1 while `running`=1, and the tick fires on the terminal count. While `running`=0 the counter is held at 0.
- FSM states are IDLE, REQ, WRITE, ACC, DISP.
  - IDLE: on tick → REQ.
  - REQ: `smp_req`=1. On `smp_ack` → WRITE. There is no timeout.
  - WRITE: `buf_wr`=1 with `buf_addr`=wr_ptr → ACC.
  - ACC: `acc_en`=1. wr_ptr increments modulo 2^WIN_LOG2. `window_full` sets if wr_ptr was 2^WIN_LOG2-1 → DISP.
  - DISP: `disp_load` = `window_full` (no display update until the first window is complete) → IDLE.
- Tick in any state other than IDLE: the tick is dropped and `overrun` sets. A tick in the same cycle the FSM enters IDLE is also dropped.
- Mode change mid-transaction: the current transaction runs to IDLE, and then no further ticks are generated.
- `smp_ack` outside REQ is ignored.
- `window_full` and `overrun` clear only on reset.

## Timing
- Reset values: `smp_req`, `buf_wr`, `acc_en`, `disp_load`, `window_full` and `overrun` = 0. `buf_addr` = 0. `running` = 1. Debounced level = 1 (released). FSM = IDLE.
- Reset asserted mid-transaction forces all of the above immediately (asynchronous) and abandons the transaction.
- All outputs are registered.
- Tick in cycle T gives `smp_req`=1 from T+1. Ack in cycle A (A ≥ T+1) drops `smp_req` in A+1. `buf_wr` is high in A+1, `acc_en` in A+2, `disp_load` in A+3, and the FSM is back in IDLE at A+4.
- `buf_addr` is stable during `buf_wr` and advances in the cycle after `acc_en`.
- Button latency: `running` toggles 2 + DEBOUNCE_CYCLES + 1 cycles after a clean press edge.

## Structure
- Shared package `avg_pkg`:
  - FSM state enum.
  - Default `WIN_LOG2`.
  - Shared with the window buffer and accumulator so their depths match.
- Sub-module `btn_debounce`: synchronizer, debounce counter and press-edge pulse output. The parent owns the `running` toggle flop.

## Test plan
All scenarios use `SAMPLE_DIV`=10, `DEBOUNCE_CYCLES`=4, `WIN_LOG2`=2.
1. Reset, run, source acks 1 cycle after each req → `buf_wr` at `buf_addr` 0,1,2,3 on successive ticks 10 cycles apart. `disp_load` stays 0 for samples 1–3 and pulses on sample 4, together with `window_full`=1.
2. Continue to samples 5 and 6 → `buf_addr` wraps to 0 then 1. `disp_load` pulses every sample and `window_full` stays 1.
3. Source delays ack by 15 cycles → exactly one tick is dropped, `overrun`=1 and stays 1. The next transaction starts on the following tick.
4. `toggleBtn` low for 2 cycles (bounce) → `running` stays 1. Low for 10 cycles → `running`=0, `smp_req` never rises, and the tick counter holds at 0. A second clean press → `running`=1.
5. Press so that `running` falls while in REQ, with ack 3 cycles later → `buf_wr`, `acc_en` and `disp_load` still occur once. Then there is no further `smp_req`.
6. Assert `reset` mid-REQ → `smp_req`=0 in the same cycle, `buf_addr`=0, `window_full`=0, `overrun`=0, `running`=1.
